regfile_param: RTL and testbench

Parametrised general-purpose register file for the pipelined processor, built as the multi-entry, multi-port successor to the single 32-bit enable/clear register. It holds DEPTH words of WIDTH bits, with one synchronous write port, two combinational read ports and a dedicated exception write port into the status register. It also provides an optional same-cycle write-to-read bypass. It sits between decode (reads) and writeback (writes).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/register_n.sv | 27 ++
 rtl/regfile_param.sv | 90 +++++++++
 tb/tb_regfile_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants for the register file: the hardwired-zero index,
//   the default exception/status index and the default geometry.
package regfile_pkg;

  localparam int ZERO_REG           = 0;
  localparam int STATUS_REG_DEFAULT = 30;
  localparam int WIDTH_DEFAULT      = 32;
  localparam int DEPTH_DEFAULT      = 32;

endpackage

// File: rtl/register_n.sv
// register_n
//   WIDTH-bit storage register with load enable and asynchronous clear.
//   Ports:
//     clk - rising-edge clock
//     clr - asynchronous active-high clear, forces q to 0
//     en  - load enable, q takes d at the rising edge
//     d   - next value
//     q   - stored value
module register_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param
//   DEPTH x WIDTH register file with one synchronous write port, a
//   dedicated exception write port into STATUS_REG, and two combinational
//   read ports with optional same-cycle write-to-read bypass.
//   Entry 0 has no storage and always reads 0.
//   Ports:
//     clk                  - rising-edge clock
//     clr                  - asynchronous active-high clear of all entries
//     we/wr_addr/wr_data   - main write port
//     exc_we/exc_data      - exception write into STATUS_REG (wins collisions)
//     rd_addr_a/rd_data_a  - read port A (combinational)
//     rd_addr_b/rd_data_b  - read port B (combinational)
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter bit BYPASS     = 1'b1,
  parameter int STATUS_REG = STATUS_REG_DEFAULT,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             exc_we,
  input  logic [WIDTH-1:0] exc_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  localparam logic [AW-1:0] ZERO_ADDR   = AW'(ZERO_REG);
  localparam logic [AW-1:0] STATUS_ADDR = AW'(STATUS_REG);

  logic [WIDTH-1:0] entries [DEPTH];

  assign entries[0] = '0;

  // Per-entry enable and data select; the exception port overrides the
  // main port when both target STATUS_REG.
  for (genvar g = 1; g < DEPTH; g++) begin : g_entry
    logic             hit_main;
    logic             hit_exc;
    logic             en;
    logic [WIDTH-1:0] d;

    assign hit_main = we && (wr_addr == AW'(g));
    assign hit_exc  = exc_we && (g == STATUS_REG);
    assign en       = hit_main || hit_exc;
    assign d        = hit_exc ? exc_data : wr_data;

    register_n #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk(clk),
      .clr(clr),
      .en (en),
      .d  (d),
      .q  (entries[g])
    );
  end

  // Read muxes. Outputs are forced to 0 while clr is high so the bypass
  // path cannot leak incoming data during reset.
  always_comb begin
    rd_data_a = entries[rd_addr_a];
    if (clr || rd_addr_a == ZERO_ADDR) begin
      rd_data_a = '0;
    end else if (BYPASS && exc_we && rd_addr_a == STATUS_ADDR) begin
      rd_data_a = exc_data;
    end else if (BYPASS && we && rd_addr_a == wr_addr) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = entries[rd_addr_b];
    if (clr || rd_addr_b == ZERO_ADDR) begin
      rd_data_b = '0;
    end else if (BYPASS && exc_we && rd_addr_b == STATUS_ADDR) begin
      rd_data_b = exc_data;
    end else if (BYPASS && we && rd_addr_b == wr_addr) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Directed bench for regfile_param: a default bypassing instance, a
//   non-bypassing instance sharing the same stimulus, and a 16x8 instance
//   with STATUS_REG=6.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        exc_we;
  logic [31:0] exc_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] nb_data_a;
  logic [31:0] nb_data_b;

  logic        s_we;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        s_exc_we;
  logic [15:0] s_exc_data;
  logic [2:0]  s_rd_addr_a;
  logic [2:0]  s_rd_addr_b;
  logic [15:0] s_rd_data_a;
  logic [15:0] s_rd_data_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_param #(.BYPASS(1'b1)) dut (
    .clk(clk), .clr(clr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .exc_we(exc_we), .exc_data(exc_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b)
  );

  regfile_param #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .clr(clr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .exc_we(exc_we), .exc_data(exc_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_data_a), .rd_data_b(nb_data_b)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .STATUS_REG(6)) dut_s (
    .clk(clk), .clr(clr), .we(s_we), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .exc_we(s_exc_we), .exc_data(s_exc_data),
    .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
    .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
    exc_we = 1'b0; exc_data = '0; rd_addr_a = 5'd5; rd_addr_b = 5'd17;
    s_we = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_exc_we = 1'b0;
    s_exc_data = '0; s_rd_addr_a = 3'd3; s_rd_addr_b = 3'd6;
    #1;
    check("reset_a", rd_data_a, 32'h0);
    check("reset_b", rd_data_b, 32'h0);
    check("reset_small_b", {16'h0, s_rd_data_b}, 32'h0);
    tick();
    clr = 1'b0;

    // Fill entries 1..31 with nonzero values.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 | 32'(i);
      tick();
    end
    we = 1'b0;
    #1;
    check("fill_17", rd_data_b, 32'h1000_0011);
    check("fill_nb_5", nb_data_a, 32'h1000_0005);

    // Mid-cycle clr, held across a write edge.
    #2;
    clr = 1'b1; we = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE_F00D;
    #1;
    check("clr_async_a", rd_data_a, 32'h0);
    check("clr_async_b", rd_data_b, 32'h0);
    check("clr_bypass_off", rd_data_a, 32'h0);
    tick();
    we = 1'b0;
    #1;
    clr = 1'b0;
    #1;
    check("post_clr_5", rd_data_a, 32'h0);
    check("post_clr_17", rd_data_b, 32'h0);
    check("post_clr_nb_5", nb_data_a, 32'h0);

    // Basic write then read.
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_addr = 5'd31; wr_data = 32'h1234_5678;
    tick();
    we = 1'b0; rd_addr_a = 5'd7; rd_addr_b = 5'd31;
    #1;
    check("wr_7", rd_data_a, 32'hDEAD_BEEF);
    check("wr_31", rd_data_b, 32'h1234_5678);
    check("wr_nb_7", nb_data_a, 32'hDEAD_BEEF);
    check("wr_nb_31", nb_data_b, 32'h1234_5678);

    // Zero register write is ignored, also through bypass.
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0;
    #1;
    check("zero_bypass", rd_data_a, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("zero_after", rd_data_a, 32'h0);
    check("zero_after_nb", nb_data_a, 32'h0);

    // Bypass vs. stored-value read.
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h1111_1111;
    tick();
    wr_data = 32'hA5A5_A5A5; rd_addr_a = 5'd9;
    #1;
    check("bypass_on", rd_data_a, 32'hA5A5_A5A5);
    check("bypass_off_old", nb_data_a, 32'h1111_1111);
    tick();
    we = 1'b0;
    #1;
    check("bypass_on_after", rd_data_a, 32'hA5A5_A5A5);
    check("bypass_off_after", nb_data_a, 32'hA5A5_A5A5);

    // Collision on STATUS_REG: exception data wins.
    we = 1'b1; wr_addr = 5'd30; wr_data = 32'h1;
    exc_we = 1'b1; exc_data = 32'h2;
    rd_addr_a = 5'd30; rd_addr_b = 5'd30;
    #1;
    check("coll_bypass_a", rd_data_a, 32'h2);
    check("coll_bypass_b", rd_data_b, 32'h2);
    check("coll_nb_old", nb_data_a, 32'h0);
    tick();
    we = 1'b0; exc_we = 1'b0;
    #1;
    check("coll_stored", rd_data_a, 32'h2);
    check("coll_stored_nb", nb_data_b, 32'h2);

    // Distinct targets: both ports commit.
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    exc_we = 1'b1; exc_data = 32'h33;
    rd_addr_a = 5'd4; rd_addr_b = 5'd30;
    #1;
    check("dual_bypass_4", rd_data_a, 32'h44);
    check("dual_bypass_30", rd_data_b, 32'h33);
    tick();
    we = 1'b0; exc_we = 1'b0;
    #1;
    check("dual_stored_4", nb_data_a, 32'h44);
    check("dual_stored_30", nb_data_b, 32'h33);

    // Main port alone can still write STATUS_REG.
    we = 1'b1; wr_addr = 5'd30; wr_data = 32'h77;
    #1;
    check("status_main_bypass", rd_data_b, 32'h77);
    tick();
    we = 1'b0;
    #1;
    check("status_main_stored", nb_data_b, 32'h77);

    // Small geometry instance.
    s_we = 1'b1; s_wr_addr = 3'd3; s_wr_data = 16'hBEEF;
    s_exc_we = 1'b1; s_exc_data = 16'h0042;
    tick();
    s_we = 1'b0; s_exc_we = 1'b0;
    #1;
    check("small_3", {16'h0, s_rd_data_a}, 32'h0000_BEEF);
    check("small_6", {16'h0, s_rd_data_b}, 32'h0000_0042);
    s_rd_addr_a = 3'd0;
    #1;
    check("small_0", {16'h0, s_rd_data_a}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
